// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle, with
// unsigned / sign-magnitude / two's-complement input and sticky overflow.
module bin2bcd_seq #(
  parameter int unsigned IN_W      = 16,
  parameter int unsigned DIGITS    = 5,
  parameter int unsigned SIGN_MODE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_neg,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [IN_W-1:0]  mag;
  logic [BCD_W-1:0] bcd;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic             ovf;

  logic [IN_W-1:0]  in_mag;
  logic             in_neg;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_nxt;
  logic             ovf_nxt;
  logic             accept;

  // A finished result can be swapped for a new input in the same cycle.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Magnitude and sign of the incoming word; a zero magnitude is never negative.
  always_comb begin
    in_mag = in_data;
    in_neg = 1'b0;
    if (SIGN_MODE == 1) begin
      in_mag = {1'b0, in_data[IN_W-2:0]};
      in_neg = in_data[IN_W-1];
    end else if (SIGN_MODE == 2) begin
      in_neg = in_data[IN_W-1];
      if (in_neg) in_mag = ~in_data + IN_W'(1);
    end
    if (in_mag == '0) in_neg = 1'b0;
  end

  // One double-dabble iteration; a bit leaving the top digit means the value overflows.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_nxt = {bcd_adj[BCD_W-2:0], mag[IN_W-1]};
    ovf_nxt = ovf || bcd_adj[BCD_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mag       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_neg   <= 1'b0;
      out_bcd   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          bcd <= bcd_nxt;
          mag <= {mag[IN_W-2:0], 1'b0};
          ovf <= ovf_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_neg   <= neg;
            out_ovf   <= ovf_nxt;
            out_bcd   <= ovf_nxt ? {DIGITS{4'h9}} : bcd_nxt;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Load overrides the IDLE/DONE transitions above.
      if (accept) begin
        mag   <= in_mag;
        neg   <= in_neg;
        bcd   <= '0;
        ovf   <= 1'b0;
        cnt   <= CNT_W'(IN_W);
        state <= SHIFT;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench: four converters (sign-mag/5, unsigned/5, unsigned/3, two's/5)
// driven in lockstep with directed vectors and hand-computed results.
module tb_bin2bcd_seq;

  localparam time CLK_P = 10;

  typedef struct {
    logic        neg;
    logic [19:0] bcd;
    logic        ovf;
    int          tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_data = 16'h0000;

  logic [3:0]  ov_v, on, oo, ir;
  logic [19:0] b0, b1, b3;
  logic [11:0] b2;
  logic [19:0] ob [4];

  exp_t        q [4][$];
  int          n_chk = 0;
  int          n_pass = 0;
  time         t_acc, t_prev;

  logic [15:0] vd [8];
  logic [19:0] vb [8][4];
  logic [3:0]  vn [8];
  logic [3:0]  vo [8];

  always #(CLK_P/2) clk = ~clk;

  bin2bcd_seq #(.IN_W(16), .DIGITS(5), .SIGN_MODE(1)) u_sm5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov_v[0]), .out_ready(out_ready), .out_neg(on[0]), .out_bcd(b0), .out_ovf(oo[0]));
  bin2bcd_seq #(.IN_W(16), .DIGITS(5), .SIGN_MODE(0)) u_us5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov_v[1]), .out_ready(out_ready), .out_neg(on[1]), .out_bcd(b1), .out_ovf(oo[1]));
  bin2bcd_seq #(.IN_W(16), .DIGITS(3), .SIGN_MODE(0)) u_us3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov_v[2]), .out_ready(out_ready), .out_neg(on[2]), .out_bcd(b2), .out_ovf(oo[2]));
  bin2bcd_seq #(.IN_W(16), .DIGITS(5), .SIGN_MODE(2)) u_tc5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .in_data(in_data),
    .out_valid(ov_v[3]), .out_ready(out_ready), .out_neg(on[3]), .out_bcd(b3), .out_ovf(oo[3]));

  always_comb begin
    ob[0] = b0;
    ob[1] = b1;
    ob[2] = {8'h00, b2};
    ob[3] = b3;
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic setv(input int v, input logic [15:0] d, input logic [19:0] e0, input logic [19:0] e1,
                      input logic [19:0] e2, input logic [19:0] e3, input logic [3:0] n, input logic [3:0] o);
    vd[v] = d;
    vb[v][0] = e0; vb[v][1] = e1; vb[v][2] = e2; vb[v][3] = e3;
    vn[v] = n;
    vo[v] = o;
  endtask

  task automatic push(input int v);
    exp_t e;
    for (int g = 0; g < 4; g++) begin
      e.neg = vn[v][g];
      e.bcd = vb[v][g];
      e.ovf = vo[v][g];
      e.tag = v;
      q[g].push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int v);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = vd[v];
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (ir == 4'hF) begin
        push(v);
        done = 1'b1;
      end
      @(posedge clk);
      if (done) t_acc = $time;
      #1;
    end
    in_valid = 1'b0;
    in_data  = 16'hA5A5;
    if (!done) check(1'b0, "accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_valid(input int lat, input string name);
    int n = 0;
    while (!ov_v[0] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(n == lat && ov_v == 4'hF, name, 64'(n), 64'(lat));
  endtask

  // Per-converter monitor: every handshaken result is popped and compared.
  for (genvar g = 0; g < 4; g++) begin : g_mon
    exp_t e;
    always @(negedge clk) begin
      if (rst_n && ov_v[g] && out_ready) begin
        if (q[g].size() == 0) begin
          check(1'b0, $sformatf("unexpected_result_dut%0d", g), 64'(ob[g]), 64'(0));
        end else begin
          e = q[g].pop_front();
          check(on[g] == e.neg && ob[g] == e.bcd && oo[g] == e.ovf,
                $sformatf("result_dut%0d_vec%0d", g, e.tag),
                64'({on[g], oo[g], ob[g]}), 64'({e.neg, e.ovf, e.bcd}));
        end
      end
    end
  end

  initial begin
    #(50000 * CLK_P);
    $display("FAIL watchdog: simulation did not finish, got %0d checks, required completion", n_chk);
    $fatal(1);
  end

  initial begin
    bit ok;
    bit seen;
    // Columns: sign-mag/5, unsigned/5, unsigned/3, two's/5; neg/ovf bit g = column g.
    setv(0, 16'h80FD, 20'h00253, 20'h33021, 20'h00999, 20'h32515, 4'b1001, 4'b0100);
    setv(1, 16'hFFFF, 20'h32767, 20'h65535, 20'h00999, 20'h00001, 4'b1001, 4'b0100);
    setv(2, 16'h0000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 4'b0000, 4'b0000);
    setv(3, 16'd999,  20'h00999, 20'h00999, 20'h00999, 20'h00999, 4'b0000, 4'b0000);
    setv(4, 16'd1000, 20'h01000, 20'h01000, 20'h00999, 20'h01000, 4'b0000, 4'b0100);
    setv(5, 16'h8000, 20'h00000, 20'h32768, 20'h00999, 20'h32768, 4'b1000, 4'b0100);
    setv(6, 16'd12345, 20'h12345, 20'h12345, 20'h00999, 20'h12345, 4'b0000, 4'b0100);
    setv(7, 16'h8001, 20'h00001, 20'h32769, 20'h00999, 20'h32767, 4'b1001, 4'b0100);

    repeat (2) @(posedge clk);
    #1;
    ok = (ov_v == 4'h0) && (on == 4'h0) && (oo == 4'h0) && (ir == 4'hF);
    for (int g = 0; g < 4; g++) ok = ok && (ob[g] == 20'h0);
    check(ok, "reset_state", 64'({ov_v, on, oo, ir}), 64'(16'h000F));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single conversion latency, then a back-to-back stream.
    out_ready = 1'b1;
    send(0);
    wait_valid(16, "latency_first");
    for (int v = 1; v < 8; v++) begin
      t_prev = t_acc;
      send(v);
      check(t_acc - t_prev == 17 * CLK_P, $sformatf("throughput_vec%0d", v),
            64'(t_acc - t_prev), 64'(17 * CLK_P));
    end
    wait_valid(16, "latency_stream_last");
    @(posedge clk);
    #1;

    // Backpressure: result must hold while the next input waits.
    out_ready = 1'b0;
    send(1);
    wait_valid(16, "latency_bp_first");
    in_valid = 1'b1;
    in_data  = vd[6];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ok = (ov_v == 4'hF) && (ir == 4'h0) && (on == vn[1]) && (oo == vo[1]);
      for (int g = 0; g < 4; g++) ok = ok && (ob[g] == vb[1][g]);
      check(ok, $sformatf("hold_cycle%0d", c), 64'({ov_v, ir, ob[1]}), 64'({4'hF, 4'h0, vb[1][1]}));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(6);
    wait_valid(16, "latency_after_bp");
    @(posedge clk);
    #1;

    // Reset in the middle of a conversion.
    send(6);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int g = 0; g < 4; g++) q[g].delete();
    #1;
    ok = (ov_v == 4'h0) && (ir == 4'hF) && (on == 4'h0) && (oo == 4'h0);
    for (int g = 0; g < 4; g++) ok = ok && (ob[g] == 20'h0);
    check(ok, "reset_abort", 64'({ov_v, ir}), 64'(8'h0F));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ov_v != 4'h0) seen = 1'b1;
    end
    check(!seen, "no_partial_result", 64'(seen), 64'(0));
    @(posedge clk);
    #1;
    send(7);
    wait_valid(16, "latency_after_reset");
    @(posedge clk);
    #1;
    @(negedge clk);

    check(q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0, "scoreboard_drained",
          64'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
